// File: rtl/l1_cache.sv
// l1_cache: two-way set-associative, write-back, write-allocate L1 data cache.
//
// Sits between a single-word CPU request port and a DRAM request FIFO. On a
// miss the victim line is written back (only if valid and dirty), then the
// missing line is fetched over the 128-bit memory interface. The FSM returns
// to COMPARE after the refill, so every response comes from the hit path.
//
// Ports:
//   sys_clk         single clock, all logic on the rising edge
//   RST             synchronous active-high reset
//   cpu_req_*       CPU request: byte address (bits [1:0] ignored), write
//                   data, rw (1=write), valid strobe (sampled in IDLE only)
//   cpu_res_data    read data (0 for writes), held until the next response
//   cpu_res_ready   one-cycle completion pulse
//   mem_req_*       DRAM request: line address, write-back line, rw, and a
//                   one-cycle valid pulse; addr/data/rw hold between requests
//   mem_data        refill line from DRAM
//   mem_data_ready  refill strobe, honoured only in WAIT_FILL
//   state           FSM state encoding for debug
//   hit_count, miss_count  (only with L1_CACHE_STATS_EN) saturating counters
//
// Build option: define L1_CACHE_STATS_EN to add the hit/miss counters.

module l1_cache #(
    parameter int INDEX_W = 8,
    parameter int LINE_W  = 128,
    parameter int ADDR_W  = 27
) (
    input  logic              sys_clk,
    input  logic              RST,
    input  logic [ADDR_W-1:0] cpu_req_addr,
    input  logic [31:0]       cpu_req_data,
    input  logic              cpu_req_rw,
    input  logic              cpu_req_valid,
    output logic [31:0]       cpu_res_data,
    output logic              cpu_res_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [LINE_W-1:0] mem_req_data,
    output logic              mem_req_rw,
    output logic              mem_req_valid,
    input  logic [LINE_W-1:0] mem_data,
    input  logic              mem_data_ready,
`ifdef L1_CACHE_STATS_EN
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count,
`endif
    output logic [2:0]        state
);

    localparam int SETS  = 1 << INDEX_W;
    localparam int TAG_W = ADDR_W - 4 - INDEX_W;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        COMPARE    = 3'd1,
        WRITE_BACK = 3'd2,
        ALLOCATE   = 3'd3,
        WAIT_FILL  = 3'd4
    } state_t;

    state_t state_reg, state_next;

    logic [ADDR_W-1:0]  addr_reg;
    logic [31:0]        wdata_reg;
    logic               rw_reg;
    logic [SETS-1:0]    valid_reg [2];
    logic [SETS-1:0]    dirty_reg [2];
    logic [SETS-1:0]    lru_reg;          // 1 = way 1 is least recently used
    logic               victim_reg;

    logic [INDEX_W-1:0] idx;
    logic [INDEX_W-1:0] rd_idx;
    logic [TAG_W-1:0]   tag;
    logic [1:0]         offset;
    logic [TAG_W-1:0]   tag_rd  [2];
    logic [LINE_W-1:0]  line_rd [2];
    logic [1:0]         hit_w;
    logic               hit, hit_way, victim_c, need_wb, rd_en;
    logic [1:0]         line_we, tag_we;
    logic [LINE_W-1:0]  line_wdata, merged_line;
    logic [31:0]        hit_word;
    logic               unused_addr_lsb;

    assign idx             = addr_reg[4 +: INDEX_W];
    assign rd_idx          = cpu_req_addr[4 +: INDEX_W];
    assign tag             = addr_reg[ADDR_W-1 -: TAG_W];
    assign offset          = addr_reg[3:2];
    assign state           = state_reg;
    assign unused_addr_lsb = ^addr_reg[1:0];

    // Tag and line storage per way. The arrays are read on the accepting edge
    // so COMPARE sees registered copies; a refill also lands in those copies
    // so the re-COMPARE after WAIT_FILL hits without another array read.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_way
            logic [TAG_W-1:0]  tag_ram  [0:SETS-1];
            logic [LINE_W-1:0] line_ram [0:SETS-1];
            logic [TAG_W-1:0]  tag_q;
            logic [LINE_W-1:0] line_q;

            always_ff @(posedge sys_clk) begin
                if (line_we[gi]) line_ram[idx] <= line_wdata;
                if (tag_we[gi])  tag_ram[idx]  <= tag;
                if (rd_en) begin
                    tag_q  <= tag_ram[rd_idx];
                    line_q <= line_ram[rd_idx];
                end else if (tag_we[gi]) begin
                    tag_q  <= tag;
                    line_q <= mem_data;
                end
            end

            assign tag_rd[gi]  = tag_q;
            assign line_rd[gi] = line_q;
            assign hit_w[gi]   = valid_reg[gi][idx] && (tag_q == tag);
        end
    endgenerate

    always_comb begin
        hit     = |hit_w;
        hit_way = ~hit_w[0];
        // Fill empty ways first (way 0 before way 1), otherwise evict the LRU way.
        if (!valid_reg[0][idx])      victim_c = 1'b0;
        else if (!valid_reg[1][idx]) victim_c = 1'b1;
        else                         victim_c = lru_reg[idx];
        need_wb     = valid_reg[victim_c][idx] && dirty_reg[victim_c][idx];
        hit_word    = line_rd[hit_way][{offset, 5'b0} +: 32];
        merged_line = line_rd[hit_way];
        merged_line[{offset, 5'b0} +: 32] = wdata_reg;
    end

    always_comb begin
        state_next = state_reg;
        rd_en      = 1'b0;
        line_we    = 2'b00;
        tag_we     = 2'b00;
        line_wdata = merged_line;
        case (state_reg)
            IDLE: begin
                if (cpu_req_valid) begin
                    rd_en      = 1'b1;
                    state_next = COMPARE;
                end
            end
            COMPARE: begin
                if (hit) begin
                    if (rw_reg) line_we[hit_way] = 1'b1;
                    state_next = IDLE;
                end else if (need_wb) begin
                    state_next = WRITE_BACK;
                end else begin
                    state_next = ALLOCATE;
                end
            end
            WRITE_BACK: state_next = ALLOCATE;
            ALLOCATE:   state_next = WAIT_FILL;
            WAIT_FILL: begin
                if (mem_data_ready) begin
                    line_we[victim_reg] = 1'b1;
                    tag_we[victim_reg]  = 1'b1;
                    line_wdata          = mem_data;
                    state_next          = COMPARE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Registered outputs are loaded on the edge that enters the issuing state,
    // so each mem_req_valid pulse lines up with WRITE_BACK or ALLOCATE.
    always_ff @(posedge sys_clk) begin
        if (RST) begin
            state_reg     <= IDLE;
            for (int w = 0; w < 2; w++) begin
                valid_reg[w] <= '0;
                dirty_reg[w] <= '0;
            end
            lru_reg       <= '0;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            rw_reg        <= 1'b0;
            victim_reg    <= 1'b0;
            cpu_res_ready <= 1'b0;
            cpu_res_data  <= '0;
            mem_req_valid <= 1'b0;
            mem_req_rw    <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_data  <= '0;
        end else begin
            state_reg     <= state_next;
            cpu_res_ready <= 1'b0;
            mem_req_valid <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (cpu_req_valid) begin
                        addr_reg  <= cpu_req_addr;
                        wdata_reg <= cpu_req_data;
                        rw_reg    <= cpu_req_rw;
                    end
                end
                COMPARE: begin
                    if (hit) begin
                        lru_reg[idx]  <= ~hit_way;
                        cpu_res_ready <= 1'b1;
                        cpu_res_data  <= rw_reg ? 32'd0 : hit_word;
                        if (rw_reg) dirty_reg[hit_way][idx] <= 1'b1;
                    end else begin
                        victim_reg    <= victim_c;
                        mem_req_valid <= 1'b1;
                        if (need_wb) begin
                            mem_req_rw   <= 1'b1;
                            mem_req_addr <= {tag_rd[victim_c], idx, 4'b0000};
                            mem_req_data <= line_rd[victim_c];
                        end else begin
                            mem_req_rw   <= 1'b0;
                            mem_req_addr <= {tag, idx, 4'b0000};
                        end
                    end
                end
                WRITE_BACK: begin
                    mem_req_valid <= 1'b1;
                    mem_req_rw    <= 1'b0;
                    mem_req_addr  <= {tag, idx, 4'b0000};
                end
                WAIT_FILL: begin
                    if (mem_data_ready) begin
                        valid_reg[victim_reg][idx] <= 1'b1;
                        dirty_reg[victim_reg][idx] <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef L1_CACHE_STATS_EN
    // refill_reg marks the COMPARE that follows a refill so it is not a hit.
    logic refill_reg;

    always_ff @(posedge sys_clk) begin
        if (RST) begin
            hit_count  <= '0;
            miss_count <= '0;
            refill_reg <= 1'b0;
        end else begin
            if (state_reg == IDLE && cpu_req_valid)         refill_reg <= 1'b0;
            if (state_reg == WAIT_FILL && mem_data_ready)   refill_reg <= 1'b1;
            if (state_reg == COMPARE) begin
                if (hit && !refill_reg && hit_count != 32'hFFFF_FFFF)
                    hit_count <= hit_count + 32'd1;
                if (!hit && miss_count != 32'hFFFF_FFFF)
                    miss_count <= miss_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_l1_cache.sv
// Self-checking bench for l1_cache. A small DRAM model answers read requests
// one cycle after seeing them and absorbs write-backs; a word-level reference
// memory gives the expected read data, queued when a request is driven and
// compared when cpu_res_ready arrives.

module tb_l1_cache;

    logic         sys_clk = 1'b0;
    logic         RST;
    logic [26:0]  cpu_req_addr;
    logic [31:0]  cpu_req_data;
    logic         cpu_req_rw;
    logic         cpu_req_valid;
    logic [31:0]  cpu_res_data;
    logic         cpu_res_ready;
    logic [26:0]  mem_req_addr;
    logic [127:0] mem_req_data;
    logic         mem_req_rw;
    logic         mem_req_valid;
    logic [127:0] mem_data;
    logic         mem_data_ready;
    logic [2:0]   state;
`ifdef L1_CACHE_STATS_EN
    logic [31:0]  hit_count;
    logic [31:0]  miss_count;
`endif

    always #5 sys_clk = ~sys_clk;

    l1_cache dut (
        .sys_clk        (sys_clk),
        .RST            (RST),
        .cpu_req_addr   (cpu_req_addr),
        .cpu_req_data   (cpu_req_data),
        .cpu_req_rw     (cpu_req_rw),
        .cpu_req_valid  (cpu_req_valid),
        .cpu_res_data   (cpu_res_data),
        .cpu_res_ready  (cpu_res_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_req_data   (mem_req_data),
        .mem_req_rw     (mem_req_rw),
        .mem_req_valid  (mem_req_valid),
        .mem_data       (mem_data),
        .mem_data_ready (mem_data_ready),
`ifdef L1_CACHE_STATS_EN
        .hit_count      (hit_count),
        .miss_count     (miss_count),
`endif
        .state          (state)
    );

    typedef struct packed {
        logic         rw;
        logic [26:0]  addr;
        logic [127:0] data;
    } memreq_t;

    memreq_t      memlog [$];
    memreq_t      mon_req;
    logic [127:0] dram [logic [26:0]];
    logic [31:0]  ref_mem [logic [24:0]];
    logic [31:0]  exp_q [$];
    logic [2:0]   trace [$];
    int           checks = 0;
    int           errors = 0;
    bit           dram_auto = 1'b1;
    int           manual_seq = 0;
    int           manual_seen = 0;
    bit           fill_pending = 1'b0;
    logic [26:0]  fill_addr;

    function automatic logic [127:0] default_line(input logic [26:0] a);
        logic [31:0] w;
        w = {5'b0, a};
        if (a == 27'h10) return {96'h0, 32'h33333333};
        return {w | 32'hA000_0000, w | 32'hB000_0000, w | 32'hC000_0000, w | 32'hD000_0000};
    endfunction

    function automatic logic [127:0] dram_line(input logic [26:0] a);
        if (dram.exists(a)) return dram[a];
        return default_line(a);
    endfunction

    function automatic logic [31:0] ref_read(input logic [26:0] a);
        logic [127:0] line;
        if (ref_mem.exists(a[26:2])) return ref_mem[a[26:2]];
        line = default_line({a[26:4], 4'b0000});
        return line[{a[3:2], 5'b0} +: 32];
    endfunction

    // DRAM model: logs every request, stores write-backs, answers reads with
    // a one-cycle-latency fill; manual_seq bumps inject a spurious strobe.
    always @(negedge sys_clk) begin
        mem_data_ready = 1'b0;
        if (fill_pending) begin
            mem_data_ready = 1'b1;
            mem_data       = dram_line(fill_addr);
            fill_pending   = 1'b0;
        end else if (manual_seq != manual_seen) begin
            manual_seen    = manual_seq;
            mem_data_ready = 1'b1;
            mem_data       = {4{32'hFFFF_FFFF}};
        end
        if (mem_req_valid === 1'b1) begin
            mon_req.rw   = mem_req_rw;
            mon_req.addr = mem_req_addr;
            mon_req.data = mem_req_data;
            memlog.push_back(mon_req);
            if (mem_req_rw) dram[mem_req_addr] = mem_req_data;
            else if (dram_auto) begin
                fill_pending = 1'b1;
                fill_addr    = mem_req_addr;
            end
        end
    end

    // One CPU transaction; starts and ends on a falling edge. poke drives a
    // stray write request while the DUT sits in WAIT_FILL.
    task automatic access(input logic [26:0] addr, input bit rw, input logic [31:0] wdata,
                          input int exp_lat, input int exp_nreq, input bit poke);
        int          start, lat;
        bit          got, poked, poke_active;
        logic [31:0] exp;
        exp_q.push_back(rw ? 32'd0 : ref_read(addr));
        if (rw) ref_mem[addr[26:2]] = wdata;
        start = memlog.size();
        trace.delete();
        cpu_req_addr  = addr;
        cpu_req_rw    = rw;
        cpu_req_data  = wdata;
        cpu_req_valid = 1'b1;
        trace.push_back(state);
        lat = 0; got = 0; poked = 0; poke_active = 0;
        while (!got && lat < 200) begin
            @(negedge sys_clk);
            lat++;
            if (lat == 1) cpu_req_valid = 1'b0;
            if (poke_active) begin
                cpu_req_valid = 1'b0;
                poke_active   = 1'b0;
            end
            if (poke && !poked && state == 3'd4) begin
                cpu_req_addr  = 27'h3030;
                cpu_req_rw    = 1'b1;
                cpu_req_data  = 32'hDEADBEEF;
                cpu_req_valid = 1'b1;
                poked = 1'b1; poke_active = 1'b1;
            end
            trace.push_back(state);
            if (cpu_res_ready === 1'b1) got = 1'b1;
        end
        cpu_req_valid = 1'b0;
        exp = exp_q.pop_front();
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL timeout addr=%h got no cpu_res_ready want one within 200 cycles", addr);
        end else begin
            if (cpu_res_data !== exp) begin
                errors++;
                $display("FAIL data addr=%h got %h want %h", addr, cpu_res_data, exp);
            end
            checks++;
            if (lat != exp_lat) begin
                errors++;
                $display("FAIL latency addr=%h got %0d want %0d", addr, lat, exp_lat);
            end
            checks++;
            if (memlog.size() - start != exp_nreq) begin
                errors++;
                $display("FAIL mem_req_count addr=%h got %0d want %0d", addr, memlog.size() - start, exp_nreq);
            end
        end
        $display("txn addr=%h rw=%0d data=%h lat=%0d mem_reqs=%0d", addr, rw, cpu_res_data, lat, memlog.size() - start);
    endtask

    task automatic test_reset();
        RST = 1'b1; cpu_req_valid = 1'b0; cpu_req_addr = '0; cpu_req_data = '0; cpu_req_rw = 1'b0;
        repeat (3) @(negedge sys_clk);
        checks++; if (state !== 3'd0)          begin errors++; $display("FAIL reset_state got %0d want 0", state); end
        checks++; if (cpu_res_ready !== 1'b0)  begin errors++; $display("FAIL reset_ready got %b want 0", cpu_res_ready); end
        checks++; if (cpu_res_data !== 32'd0)  begin errors++; $display("FAIL reset_res_data got %h want 0", cpu_res_data); end
        checks++; if (mem_req_valid !== 1'b0)  begin errors++; $display("FAIL reset_mem_valid got %b want 0", mem_req_valid); end
        checks++; if (mem_req_rw !== 1'b0)     begin errors++; $display("FAIL reset_mem_rw got %b want 0", mem_req_rw); end
        checks++; if (mem_req_addr !== 27'd0)  begin errors++; $display("FAIL reset_mem_addr got %h want 0", mem_req_addr); end
        checks++; if (mem_req_data !== 128'd0) begin errors++; $display("FAIL reset_mem_data got %h want 0", mem_req_data); end
        RST = 1'b0;
        $display("txn reset state=%0d", state);
    endtask

    task automatic test_read_miss_hit();
        int start;
        start = memlog.size();
        access(27'h0000010, 1'b0, 32'd0, 5, 1, 1'b0);
        checks++;
        if (memlog.size() <= start || memlog[start].rw !== 1'b0 || memlog[start].addr !== 27'h10) begin
            errors++;
            $display("FAIL fill_request got rw/addr %b/%h want 0/0000010",
                     memlog.size() > start ? memlog[start].rw : 1'bx,
                     memlog.size() > start ? memlog[start].addr : 27'bx);
        end
        access(27'h0000010, 1'b0, 32'd0, 2, 0, 1'b0);
    endtask

    task automatic test_write_hit();
        access(27'h0000014, 1'b1, 32'h1C71C71C, 2, 0, 1'b0);
        access(27'h0000014, 1'b0, 32'd0, 2, 0, 1'b0);
    endtask

    task automatic test_eviction();
        int start;
        access(27'h0001010, 1'b0, 32'd0, 5, 1, 1'b0);
        start = memlog.size();
        access(27'h0002010, 1'b0, 32'd0, 6, 2, 1'b0);
        checks++;
        if (memlog.size() < start + 2) begin
            errors++;
            $display("FAIL writeback_present got %0d requests want 2", memlog.size() - start);
        end else begin
            if (memlog[start].rw !== 1'b1 || memlog[start].addr !== 27'h10) begin
                errors++;
                $display("FAIL writeback_req got rw/addr %b/%h want 1/0000010", memlog[start].rw, memlog[start].addr);
            end
            checks++;
            if (memlog[start].data[63:32] !== 32'h1C71C71C || memlog[start].data[31:0] !== 32'h33333333) begin
                errors++;
                $display("FAIL writeback_data got %h want word1 1c71c71c word0 33333333", memlog[start].data);
            end
            checks++;
            if (memlog[start+1].rw !== 1'b0 || memlog[start+1].addr !== 27'h2010) begin
                errors++;
                $display("FAIL evict_fill_req got rw/addr %b/%h want 0/0002010", memlog[start+1].rw, memlog[start+1].addr);
            end
        end
        // Evicted line comes back from DRAM with the written-back word intact.
        access(27'h0000010, 1'b0, 32'd0, 5, 1, 1'b0);
        access(27'h0000014, 1'b0, 32'd0, 2, 0, 1'b0);
    endtask

    task automatic test_write_miss();
        logic [23:0] code;
        int          n;
        access(27'h0123458, 1'b1, 32'h0F0F0F0F, 5, 1, 1'b0);
        code = '0; n = 0;
        for (int i = 0; i < trace.size(); i++) begin
            if (i == 0 || trace[i] != trace[i-1]) begin
                code = {code[19:0], 1'b0, trace[i]};
                n++;
            end
        end
        checks++;
        if (n != 6 || code !== 24'h013410) begin
            errors++;
            $display("FAIL state_sequence got %0d states %h want 6 states 013410", n, code);
        end
        access(27'h0123458, 1'b0, 32'd0, 2, 0, 1'b0);
        access(27'h012345C, 1'b0, 32'd0, 2, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        access(27'h0000024, 1'b1, 32'h5555AAAA, 5, 1, 1'b0);
        access(27'h0000024, 1'b0, 32'd0, 2, 0, 1'b0);
        access(27'h0000028, 1'b0, 32'd0, 2, 0, 1'b0);
    endtask

    task automatic test_reset_midmiss();
        int start, n;
        bit saw;
        start = memlog.size();
        dram_auto     = 1'b0;
        cpu_req_addr  = 27'h3030;
        cpu_req_rw    = 1'b0;
        cpu_req_valid = 1'b1;
        @(negedge sys_clk);
        cpu_req_valid = 1'b0;
        n = 0;
        while (state !== 3'd4 && n < 20) begin
            @(negedge sys_clk);
            n++;
        end
        checks++;
        if (state !== 3'd4) begin errors++; $display("FAIL reach_wait_fill got %0d want 4", state); end
        RST = 1'b1;
        @(negedge sys_clk);
        RST = 1'b0;
        manual_seq++;
        saw = 1'b0;
        repeat (6) begin
            @(negedge sys_clk);
            if (cpu_res_ready !== 1'b0) saw = 1'b1;
        end
        checks++; if (saw)                       begin errors++; $display("FAIL abandon_ready got 1 want 0"); end
        checks++; if (state !== 3'd0)            begin errors++; $display("FAIL abandon_state got %0d want 0", state); end
        checks++; if (memlog.size() - start != 1) begin errors++; $display("FAIL abandon_reqs got %0d want 1", memlog.size() - start); end
        $display("txn reset_midmiss state=%0d", state);
        dram_auto = 1'b1;
        access(27'h0003030, 1'b0, 32'd0, 5, 1, 1'b0);
    endtask

    task automatic test_spurious();
        bit saw;
        manual_seq++;
        repeat (3) @(negedge sys_clk);
        checks++;
        if (state !== 3'd0 || cpu_res_ready !== 1'b0) begin
            errors++;
            $display("FAIL spurious_idle got state %0d ready %b want 0 0", state, cpu_res_ready);
        end
        access(27'h0003030, 1'b0, 32'd0, 2, 0, 1'b0);
        access(27'h0004040, 1'b0, 32'd0, 5, 1, 1'b1);
        saw = 1'b0;
        repeat (4) begin
            @(negedge sys_clk);
            if (cpu_res_ready !== 1'b0) saw = 1'b1;
        end
        checks++;
        if (saw) begin errors++; $display("FAIL stray_request got extra cpu_res_ready want none"); end
        access(27'h0003030, 1'b0, 32'd0, 2, 0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_read_miss_hit();
        test_write_hit();
        test_eviction();
        test_write_miss();
        test_back_to_back();
        test_reset_midmiss();
        test_spurious();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
